// File: rtl/encryption_sequencer_if.sv
// Signal bundle between the XOR encryption sequencer and its surroundings:
// key table load, packet control, plaintext/ciphertext streams and the core handshake.
interface encryption_sequencer_if #(
  parameter int KEY_AW = 3
);
  logic              KeyWe;
  logic [KEY_AW-1:0] KeyAddr;
  logic [7:0]        KeyWData;
  logic [KEY_AW:0]   NumKeys;
  logic              Start;
  logic [7:0]        SizeOfData;
  logic [7:0]        InData;
  logic              InValid;
  logic              InReady;
  logic [7:0]        EncDataIn;
  logic [7:0]        EncKey;
  logic              EncAck;
  logic [7:0]        EncDataOut;
  logic              EncReady;
  logic [7:0]        OutData;
  logic              OutValid;
  logic              OutReady;
  logic              OutLast;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport slave (
    input  KeyWe, KeyAddr, KeyWData, NumKeys, Start, SizeOfData,
    input  InData, InValid, EncDataOut, EncReady, OutReady,
    output InReady, EncDataIn, EncKey, EncAck,
    output OutData, OutValid, OutLast, Busy, Done, Err
  );

  modport master (
    output KeyWe, KeyAddr, KeyWData, NumKeys, Start, SizeOfData,
    output InData, InValid, EncDataOut, EncReady, OutReady,
    input  InReady, EncDataIn, EncKey, EncAck,
    input  OutData, OutValid, OutLast, Busy, Done, Err
  );
endinterface

// File: rtl/encryption_sequencer.sv
// Feeds plaintext bytes paired with round-robin key table entries through the
// byte-wise XOR core and streams the ciphertext out, one byte in flight at a time.
//
// state | meaning
// IDLE  | waiting for Start; key table writable
// FETCH | InReady high, waiting for a plaintext byte
// ACK   | EncAck pulse to the core
// WAIT  | core computing DataIn ^ key
// CAPT  | waiting for EncReady, then capture EncDataOut
// OUT   | OutValid held until downstream handshake
module encryption_sequencer #(
  parameter int MAX_KEYS = 8,
  parameter int KEY_AW   = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  encryption_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ACK,
    WAIT,
    CAPT,
    OUT
  } state_t;

  localparam logic [KEY_AW:0] KEYS_MAX = (KEY_AW + 1)'(MAX_KEYS);

  state_t            state;
  logic [KEY_AW-1:0] kidx;
  logic [KEY_AW-1:0] last_kidx;
  logic [7:0]        count;
  logic [7:0]        last_cnt;
  logic [7:0]        key_tab [MAX_KEYS];
  logic              start_ok;

  assign start_ok = (bus.SizeOfData != 8'd0) && (bus.NumKeys != '0) &&
                    (bus.NumKeys <= KEYS_MAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      kidx          <= '0;
      last_kidx     <= '0;
      count         <= '0;
      last_cnt      <= '0;
      for (int i = 0; i < MAX_KEYS; i++) key_tab[i] <= '0;
      bus.InReady   <= 1'b0;
      bus.EncDataIn <= '0;
      bus.EncKey    <= '0;
      bus.EncAck    <= 1'b0;
      bus.OutData   <= '0;
      bus.OutValid  <= 1'b0;
      bus.OutLast   <= 1'b0;
      bus.Busy      <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Err       <= 1'b0;
    end else begin
      bus.Done <= 1'b0;
      bus.Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.KeyWe) key_tab[bus.KeyAddr] <= bus.KeyWData;
          if (bus.Start) begin
            if (start_ok) begin
              // Keep last-index copies so mid-packet changes to the inputs are harmless.
              last_kidx   <= KEY_AW'(bus.NumKeys - 1'b1);
              last_cnt    <= bus.SizeOfData - 8'd1;
              kidx        <= '0;
              count       <= '0;
              bus.InReady <= 1'b1;
              bus.Busy    <= 1'b1;
              state       <= FETCH;
            end else begin
              bus.Err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (bus.InValid && bus.InReady) begin
            bus.EncDataIn <= bus.InData;
            bus.EncKey    <= key_tab[kidx];
            bus.InReady   <= 1'b0;
            bus.EncAck    <= 1'b1;
            state         <= ACK;
          end
        end
        ACK: begin
          bus.EncAck <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          state <= CAPT;
        end
        CAPT: begin
          if (bus.EncReady) begin
            bus.OutData  <= bus.EncDataOut;
            bus.OutValid <= 1'b1;
            bus.OutLast  <= (count == last_cnt);
            state        <= OUT;
          end
        end
        OUT: begin
          if (bus.OutReady) begin
            bus.OutValid <= 1'b0;
            bus.OutLast  <= 1'b0;
            if (count == last_cnt) begin
              bus.Busy <= 1'b0;
              bus.Done <= 1'b1;
              state    <= IDLE;
            end else begin
              count       <= count + 8'd1;
              kidx        <= (kidx == last_kidx) ? '0 : kidx + 1'b1;
              bus.InReady <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encryption_sequencer.sv
// Directed bench for encryption_sequencer: table of packets plus hand-written
// sequences for back-pressure, rejected starts, mid-packet reset and busy-time writes.
module tb_encryption_sequencer;
  localparam int MAX_KEYS = 8;
  localparam int KEY_AW   = 3;

  logic Clk = 1'b0;
  logic Reset;

  encryption_sequencer_if #(.KEY_AW(KEY_AW)) bus ();

  encryption_sequencer #(.MAX_KEYS(MAX_KEYS), .KEY_AW(KEY_AW)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural XOR core: Ready drops on Ack, returns 1+core_delay cycles later.
  int core_delay = 0;
  int core_cnt   = 0;
  always @(posedge Clk) begin
    if (Reset) begin
      bus.EncReady   <= 1'b1;
      bus.EncDataOut <= 8'h00;
      core_cnt       <= 0;
    end else if (bus.EncAck) begin
      bus.EncReady <= 1'b0;
      core_cnt     <= core_delay + 1;
    end else if (core_cnt > 0) begin
      if (core_cnt == 1) begin
        bus.EncDataOut <= bus.EncDataIn ^ bus.EncKey;
        bus.EncReady   <= 1'b1;
      end
      core_cnt <= core_cnt - 1;
    end
  end

  int   ack_cycles = 0;
  int   ack_pulses = 0;
  int   err_cnt    = 0;
  logic ack_prev   = 1'b0;
  always @(posedge Clk) begin
    if (bus.EncAck) ack_cycles <= ack_cycles + 1;
    if (bus.EncAck && !ack_prev) ack_pulses <= ack_pulses + 1;
    ack_prev <= bus.EncAck;
    if (bus.Err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int               nkeys;
    int               size;
    int               delay;
    logic [7:0][7:0]  keys;
    logic [11:0][7:0] din;
    logic [11:0][7:0] dout;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic write_key(input int a, input logic [7:0] d);
    bus.KeyWe    = 1'b1;
    bus.KeyAddr  = KEY_AW'(a);
    bus.KeyWData = d;
    tick();
    bus.KeyWe = 1'b0;
  endtask

  task automatic start_pkt(input int nk, input int sz);
    bus.NumKeys    = (KEY_AW + 1)'(nk);
    bus.SizeOfData = 8'(sz);
    bus.Start      = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_outvalid(input string tag, output int n);
    n = 0;
    while (!bus.OutValid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_outvalid"}, bus.OutValid, 1);
  endtask

  // Offers one byte, waits for ciphertext, checks it, then lets the handshake happen.
  task automatic send_byte(input string tag, input logic [7:0] d, input logic [7:0] exp,
                           input logic last, input int exp_lat);
    int n;
    bus.InData  = d;
    bus.InValid = 1'b1;
    n = 0;
    while (!bus.InReady && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_inready"}, bus.InReady, 1);
    tick();
    bus.InValid = 1'b0;
    wait_outvalid(tag, n);
    if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_data"}, bus.OutData, exp);
    check({tag, "_last"}, bus.OutLast, last);
    tick();
  endtask

  initial begin
    int a0, p0, e0, n;
    logic stable;

    vecs[0] = '{nkeys: 1, size: 3, delay: 0, keys: '0, din: '0, dout: '0};
    vecs[0].keys[0] = 8'hA5;
    vecs[0].din[0] = 8'h00; vecs[0].din[1] = 8'hFF; vecs[0].din[2] = 8'h5A;
    vecs[0].dout[0] = 8'hA5; vecs[0].dout[1] = 8'h5A; vecs[0].dout[2] = 8'hFF;

    vecs[1] = '{nkeys: 3, size: 5, delay: 0, keys: '0, din: '0, dout: '0};
    vecs[1].keys[0] = 8'h01; vecs[1].keys[1] = 8'h02; vecs[1].keys[2] = 8'h03;
    vecs[1].dout[0] = 8'h01; vecs[1].dout[1] = 8'h02; vecs[1].dout[2] = 8'h03;
    vecs[1].dout[3] = 8'h01; vecs[1].dout[4] = 8'h02;

    vecs[2] = '{nkeys: 2, size: 4, delay: 2, keys: '0, din: '0, dout: '0};
    vecs[2].keys[0] = 8'h0F; vecs[2].keys[1] = 8'hF0;
    vecs[2].din[0] = 8'h11; vecs[2].din[1] = 8'h22; vecs[2].din[2] = 8'h33; vecs[2].din[3] = 8'h44;
    vecs[2].dout[0] = 8'h1E; vecs[2].dout[1] = 8'hD2; vecs[2].dout[2] = 8'h3C; vecs[2].dout[3] = 8'hB4;

    vecs[3] = '{nkeys: 8, size: 9, delay: 0, keys: '0, din: '0, dout: '0};
    for (int k = 0; k < 8; k++) vecs[3].keys[k] = 8'h80 + 8'(k);
    for (int k = 0; k < 9; k++) vecs[3].din[k] = 8'h01;
    vecs[3].dout[0] = 8'h81; vecs[3].dout[1] = 8'h80; vecs[3].dout[2] = 8'h83;
    vecs[3].dout[3] = 8'h82; vecs[3].dout[4] = 8'h85; vecs[3].dout[5] = 8'h84;
    vecs[3].dout[6] = 8'h87; vecs[3].dout[7] = 8'h86; vecs[3].dout[8] = 8'h81;

    Reset          = 1'b1;
    bus.KeyWe      = 1'b0;
    bus.KeyAddr    = '0;
    bus.KeyWData   = '0;
    bus.NumKeys    = '0;
    bus.Start      = 1'b0;
    bus.SizeOfData = '0;
    bus.InData     = '0;
    bus.InValid    = 1'b0;
    bus.OutReady   = 1'b1;
    repeat (3) tick();
    check("reset_ctrl", {bus.InReady, bus.EncAck, bus.OutValid, bus.OutLast,
                         bus.Busy, bus.Done, bus.Err}, 0);
    check("reset_data", {bus.EncDataIn, bus.EncKey, bus.OutData}, 0);
    Reset = 1'b0;
    tick();

    // Table-driven packets
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].nkeys; k++) write_key(k, vecs[v].keys[k]);
      core_delay = vecs[v].delay;
      a0 = ack_cycles;
      p0 = ack_pulses;
      start_pkt(vecs[v].nkeys, vecs[v].size);
      check($sformatf("v%0d_busy", v), bus.Busy, 1);
      for (int i = 0; i < vecs[v].size; i++)
        send_byte($sformatf("v%0d_b%0d", v, i), vecs[v].din[i], vecs[v].dout[i],
                  i == vecs[v].size - 1, 3 + vecs[v].delay);
      check($sformatf("v%0d_done", v), {bus.Done, bus.Busy}, 2'b10);
      tick();
      check($sformatf("v%0d_done_pulse", v), bus.Done, 0);
      check($sformatf("v%0d_ack_cycles", v), ack_cycles - a0, vecs[v].size);
      check($sformatf("v%0d_ack_pulses", v), ack_pulses - p0, vecs[v].size);
    end
    core_delay = 0;

    // Back-pressure: OutReady low for 10 cycles on byte 0
    write_key(0, 8'h3C);
    start_pkt(1, 2);
    bus.OutReady = 1'b0;
    send_byte("stall_b0", 8'hC3, 8'hFF, 1'b0, 3);
    a0 = ack_cycles;
    stable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (!(bus.OutValid === 1'b1 && bus.OutData === 8'hFF && bus.InReady === 1'b0 &&
            bus.OutLast === 1'b0 && bus.EncAck === 1'b0)) stable = 1'b0;
      tick();
    end
    check("stall_stable", stable, 1);
    check("stall_no_ack", ack_cycles - a0, 0);
    bus.OutReady = 1'b1;
    tick();
    check("stall_release", {bus.OutValid, bus.InReady}, 2'b01);
    send_byte("stall_b1", 8'h00, 8'h3C, 1'b1, 3);
    check("stall_done", bus.Done, 1);
    tick();

    // Rejected starts
    e0 = err_cnt;
    a0 = ack_cycles;
    start_pkt(1, 0);
    check("err_size0", {bus.Err, bus.Busy}, 2'b10);
    tick();
    check("err_pulse", bus.Err, 0);
    start_pkt(0, 3);
    check("err_nk0", {bus.Err, bus.Busy}, 2'b10);
    start_pkt(9, 3);
    check("err_nk9", {bus.Err, bus.Busy}, 2'b10);
    tick();
    check("err_count", err_cnt - e0, 3);
    check("err_no_ack", ack_cycles - a0, 0);
    check("err_idle", {bus.InReady, bus.Busy}, 0);

    // Reset during WAIT of byte 2 of 4
    write_key(0, 8'h0F);
    write_key(1, 8'hF0);
    start_pkt(2, 4);
    send_byte("rst_b0", 8'h00, 8'h0F, 1'b0, 3);
    bus.InData  = 8'h11;
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    check("rst_in_ack", bus.EncAck, 1);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_mid_ctrl", {bus.InReady, bus.EncAck, bus.OutValid, bus.OutLast,
                           bus.Busy, bus.Done, bus.Err}, 0);
    check("rst_mid_data", {bus.EncDataIn, bus.EncKey, bus.OutData}, 0);
    tick();
    check("rst_no_done", {bus.Done, bus.OutValid, bus.Busy}, 0);
    // Key 2 left unwritten: the table was cleared by reset
    write_key(0, 8'h0F);
    write_key(1, 8'hF0);
    start_pkt(3, 3);
    send_byte("post_b0", 8'h00, 8'h0F, 1'b0, 3);
    send_byte("post_b1", 8'h00, 8'hF0, 1'b0, 3);
    send_byte("post_b2", 8'h55, 8'h55, 1'b1, 3);
    check("post_done", bus.Done, 1);
    tick();

    // Start/KeyWe while busy, plus mid-packet parameter changes
    write_key(0, 8'h77);
    start_pkt(1, 2);
    a0 = ack_cycles;
    p0 = ack_pulses;
    e0 = err_cnt;
    bus.InData  = 8'h10;
    bus.InValid = 1'b1;
    tick();
    bus.InValid    = 1'b0;
    bus.KeyWe      = 1'b1;
    bus.KeyAddr    = '0;
    bus.KeyWData   = 8'hEE;
    bus.Start      = 1'b1;
    bus.SizeOfData = 8'd0;
    bus.NumKeys    = '0;
    tick();
    bus.KeyWe = 1'b0;
    bus.Start = 1'b0;
    wait_outvalid("busy_b0", n);
    check("busy_b0_data", bus.OutData, 8'h67);
    check("busy_b0_last", bus.OutLast, 0);
    tick();
    send_byte("busy_b1", 8'h01, 8'h76, 1'b1, 3);
    check("busy_done", {bus.Done, bus.Busy}, 2'b10);
    tick();
    check("busy_no_err", err_cnt - e0, 0);
    check("busy_ack_cycles", ack_cycles - a0, 2);
    check("busy_ack_pulses", ack_pulses - p0, 2);

    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
